eit_scan_sequencer: RTL

EIT_SCAN_SEQUENCER -- requirements
Module: eit_scan_sequencer

---
 rtl/eit_scan_sequencer_if.sv | 30 +++
 rtl/eit_scan_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/eit_scan_sequencer_if.sv
// Handshake bundle between the EIT scan sequencer and its ADC/electrode-mux environment.
// master = sequencer side, slave = controller/ADC side.
interface eit_scan_sequencer_if;
  logic       start;
  logic       stop;
  logic       adc_ready;
  logic       adc_sample_valid;
  logic [3:0] inj_src;
  logic [3:0] inj_sink;
  logic       mux_en;
  logic       adc_start;
  logic [3:0] step_idx;
  logic [7:0] sample_cnt;
  logic       step_done;
  logic       frame_done;
  logic       busy;
  logic       timeout_error;

  modport master (
    input  start, stop, adc_ready, adc_sample_valid,
    output inj_src, inj_sink, mux_en, adc_start, step_idx, sample_cnt,
           step_done, frame_done, busy, timeout_error
  );

  modport slave (
    output start, stop, adc_ready, adc_sample_valid,
    input  inj_src, inj_sink, mux_en, adc_start, step_idx, sample_cnt,
           step_done, frame_done, busy, timeout_error
  );
endinterface

// File: rtl/eit_scan_sequencer.sv
// Adjacent-pattern EIT injection sequencer: settle, trigger AVG_N ADC sample sets per step.
// Optional ADC watchdog enabled by defining EIT_TIMEOUT_EN.
module eit_scan_sequencer #(
  parameter int unsigned NUM_ELEC    = 16,
  parameter int unsigned SETTLE_CYC  = 200,
  parameter int unsigned AVG_N       = 4,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  eit_scan_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SETUP       = 3'd1,
    SETTLE      = 3'd2,
    TRIGGER     = 3'd3,
    WAIT_SAMPLE = 3'd4,
    NEXT        = 3'd5,
    ABORT       = 3'd6
  } state_t;

  localparam logic [3:0]  LAST_STEP   = 4'(NUM_ELEC - 1);
  localparam logic [7:0]  LAST_SAMPLE = 8'(AVG_N - 1);
  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYC - 1);

  if ((NUM_ELEC < 4) || (NUM_ELEC > 16) || (SETTLE_CYC < 1) || (SETTLE_CYC > 65535) ||
      (AVG_N < 1) || (AVG_N > 255) || (TIMEOUT_CYC < 2)) begin : g_bad_params
    $error("eit_scan_sequencer: parameter out of legal range");
  end

  state_t      state_r;
  logic [3:0]  step_idx_r;
  logic [3:0]  inj_src_r;
  logic [3:0]  inj_sink_r;
  logic [7:0]  sample_cnt_r;
  logic [15:0] settle_cnt_r;
  logic        mux_en_r;
  logic        adc_start_r;
  logic        step_done_r;
  logic        frame_done_r;
  logic        busy_r;
  logic        stop_pend_r;

`ifdef EIT_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  // The counter starts on entry to WAIT_SAMPLE, one cycle after adc_start.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 2);
  logic [TMO_W-1:0] tmo_cnt_r;
  logic             timeout_error_r;
`endif

  // Scan FSM: every output is a register updated on the transition that implies it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      step_idx_r   <= 4'd0;
      inj_src_r    <= 4'd0;
      inj_sink_r   <= 4'd0;
      sample_cnt_r <= 8'd0;
      settle_cnt_r <= 16'd0;
      mux_en_r     <= 1'b0;
      adc_start_r  <= 1'b0;
      step_done_r  <= 1'b0;
      frame_done_r <= 1'b0;
      busy_r       <= 1'b0;
      stop_pend_r  <= 1'b0;
`ifdef EIT_TIMEOUT_EN
      tmo_cnt_r       <= '0;
      timeout_error_r <= 1'b0;
`endif
    end else begin
      adc_start_r  <= 1'b0;
      step_done_r  <= 1'b0;
      frame_done_r <= 1'b0;
      if ((state_r != IDLE) && bus.stop) begin
        stop_pend_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (bus.start && bus.adc_ready) begin
            state_r     <= SETUP;
            busy_r      <= 1'b1;
            stop_pend_r <= 1'b0;
`ifdef EIT_TIMEOUT_EN
            timeout_error_r <= 1'b0;
`endif
          end
        end
        SETUP: begin
          inj_src_r    <= step_idx_r;
          inj_sink_r   <= (step_idx_r == LAST_STEP) ? 4'd0 : step_idx_r + 4'd1;
          mux_en_r     <= 1'b1;
          sample_cnt_r <= 8'd0;
          settle_cnt_r <= SETTLE_LOAD;
          state_r      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt_r == 16'd0) begin
            state_r     <= TRIGGER;
            adc_start_r <= 1'b1;
          end else begin
            settle_cnt_r <= settle_cnt_r - 16'd1;
          end
        end
        TRIGGER: begin
          state_r <= WAIT_SAMPLE;
`ifdef EIT_TIMEOUT_EN
          tmo_cnt_r <= '0;
`endif
        end
        WAIT_SAMPLE: begin
          if (bus.adc_sample_valid) begin
            sample_cnt_r <= sample_cnt_r + 8'd1;
            if (sample_cnt_r == LAST_SAMPLE) begin
              state_r <= NEXT;
            end else begin
              state_r     <= TRIGGER;
              adc_start_r <= 1'b1;
            end
`ifdef EIT_TIMEOUT_EN
          end else if (tmo_cnt_r == TMO_LAST) begin
            timeout_error_r <= 1'b1;
            mux_en_r        <= 1'b0;
            step_idx_r      <= 4'd0;
            sample_cnt_r    <= 8'd0;
            busy_r          <= 1'b0;
            state_r         <= IDLE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 1'b1;
`endif
          end
        end
        NEXT: begin
          step_done_r <= 1'b1;
          // A stop raised during this very cycle still counts as pending.
          if (stop_pend_r || bus.stop) begin
            stop_pend_r <= 1'b0;
            state_r     <= ABORT;
          end else if (step_idx_r == LAST_STEP) begin
            frame_done_r <= 1'b1;
            step_idx_r   <= 4'd0;
            mux_en_r     <= 1'b0;
            busy_r       <= 1'b0;
            state_r      <= IDLE;
          end else begin
            step_idx_r <= step_idx_r + 4'd1;
            state_r    <= SETUP;
          end
        end
        ABORT: begin
          mux_en_r     <= 1'b0;
          step_idx_r   <= 4'd0;
          sample_cnt_r <= 8'd0;
          busy_r       <= 1'b0;
          state_r      <= IDLE;
        end
        default: begin
          mux_en_r <= 1'b0;
          busy_r   <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

  assign bus.inj_src    = inj_src_r;
  assign bus.inj_sink   = inj_sink_r;
  assign bus.mux_en     = mux_en_r;
  assign bus.adc_start  = adc_start_r;
  assign bus.step_idx   = step_idx_r;
  assign bus.sample_cnt = sample_cnt_r;
  assign bus.step_done  = step_done_r;
  assign bus.frame_done = frame_done_r;
  assign bus.busy       = busy_r;
`ifdef EIT_TIMEOUT_EN
  assign bus.timeout_error = timeout_error_r;
`else
  assign bus.timeout_error = 1'b0;
`endif

endmodule
